// File: rtl/inst_enc.sv
// Program-load instruction encoder: accepts decoded fields over a valid/ready
// handshake, packs them into 32-bit words and writes them to program memory.
module inst_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opc,
    input  logic [3:0]  in_func,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [15:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] count,
    output logic        err
);

    localparam logic [3:0] OPC_CALC  = 4'b0000;
    localparam logic [3:0] OPC_CALCI = 4'b0001;
    localparam logic [3:0] OPC_LOAD  = 4'b0011;
    localparam logic [3:0] OPC_STORE = 4'b0111;
    localparam logic [3:0] OPC_CALIF = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_last;
    logic [15:0] r_count;
    logic        r_err;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_xfer;

    assign w_xfer = (r_state == S_ACCEPT) && in_valid;

    // Field packing per opcode; CALC and CALCI relocate func into otherwise unused slots.
    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        case (in_opc)
            OPC_CALC:  w_word = {12'h000, in_func, in_rd, in_rs2, in_rs1, in_opc};
            OPC_CALCI: w_word = {in_imm, in_rd, in_func, in_rs1, in_opc};
            OPC_LOAD,
            OPC_CALIF: w_word = {in_imm, in_rd, in_rs2, in_rs1, in_opc};
            OPC_STORE: w_word = {in_imm, 4'h0, in_rs2, in_rs1, in_opc};
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ACCEPT;
            S_ACCEPT: begin
                if (w_xfer) begin
                    if (w_legal)      w_next = S_WRITE;
                    else if (in_last) w_next = S_DONE;
                end
            end
            S_WRITE:  if (mem_ack) w_next = r_last ? S_DONE : S_ACCEPT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Reset discards any pending word; nothing is retried afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 16'h0;
            r_wdata <= 32'h0;
            r_last  <= 1'b0;
            r_count <= 16'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_count <= 16'h0;
                        r_err   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_last  <= in_last;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_addr  <= r_addr + 16'd1;
                        r_count <= r_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_ACCEPT);
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign count     = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_inst_enc.sv
// Randomized bench for inst_enc against a transaction-level model of the
// encoding rules, address/count bookkeeping and session handshake.
module tb_inst_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opc, in_func, in_rd, in_rs1, in_rs2;
    logic [15:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy, done, err;
    logic [15:0] count;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_addr;
    logic [15:0] m_count;
    logic        m_err;

    inst_enc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
        .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit ref_legal(input int unsigned opc);
        return opc == 0 || opc == 1 || opc == 3 || opc == 7 || opc == 15;
    endfunction

    function automatic logic [31:0] ref_enc(input int unsigned opc, func, rd, rs1, rs2, imm);
        int unsigned w;
        case (opc)
            0:       w = func * 65536 + rd * 4096 + rs2 * 256 + rs1 * 16 + opc;
            1:       w = imm * 65536 + rd * 4096 + func * 256 + rs1 * 16 + opc;
            7:       w = imm * 65536 + rs2 * 256 + rs1 * 16 + opc;
            default: w = imm * 65536 + rd * 4096 + rs2 * 256 + rs1 * 16 + opc;
        endcase
        return w;
    endfunction

    // Called at a falling edge in IDLE; returns at a falling edge in ACCEPT.
    task automatic start_sess(input logic [15:0] b);
        chk("idle_ready", in_ready, 1'b0);
        chk("idle_busy", busy, 1'b0);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        base_addr = 16'($urandom);
        m_addr = b;
        m_count = 16'h0;
        m_err = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_count", count, 16'h0);
        chk("start_err", err, 1'b0);
    endtask

    // Called at a falling edge in ACCEPT; dly = cycles ack is withheld.
    task automatic send_word(input logic [3:0] opc, func, rd, rs1, rs2,
                             input logic [15:0] imm, input logic last, input int dly);
        logic [31:0] exp;
        exp = ref_enc(opc, func, rd, rs1, rs2, imm);
        chk("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_opc = opc; in_func = func; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b0;
        in_opc = 4'($urandom); in_imm = 16'($urandom); in_last = 1'($urandom);
        if (ref_legal(opc)) begin
            for (int k = 0; k <= dly; k++) begin
                chk("wr_we", mem_we, 1'b1);
                chk("wr_addr", mem_addr, m_addr);
                chk("wr_data", mem_wdata, exp);
                chk("wr_ready", in_ready, 1'b0);
                start = 1'($urandom_range(0, 1));
                mem_ack = (k == dly);
                @(negedge clk);
                mem_ack = 1'b0;
                start = 1'b0;
            end
            m_addr = m_addr + 16'd1;
            m_count = m_count + 16'd1;
        end else begin
            m_err = 1'b1;
            chk("bad_we", mem_we, 1'b0);
        end
        chk("err", err, m_err);
        chk("count", count, m_count);
        if (last) begin
            chk("done_hi", done, 1'b1);
            chk("done_busy", busy, 1'b1);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("done_lo", done, 1'b0);
            chk("end_busy", busy, 1'b0);
            chk("end_count", count, m_count);
            chk("end_err", err, m_err);
        end else begin
            chk("next_ready", in_ready, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; in_valid = 1'b0;
        in_opc = 4'h0; in_func = 4'h0; in_rd = 4'h0; in_rs1 = 4'h0;
        in_rs2 = 4'h0; in_imm = 16'h0; in_last = 1'b0; mem_ack = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_data", mem_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", count, 16'h0);
        chk("rst_err", err, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        // Quiet after reset: ack in IDLE must have no effect.
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        chk("quiet_busy", busy, 1'b0);
        chk("quiet_count", count, 16'h0);

        // CALC single word, immediate ack
        start_sess(16'h0100);
        send_word(4'h0, 4'd3, 4'd2, 4'd4, 4'd5, 16'h1234, 1'b1, 0);
        // CALCI with ack withheld 3 cycles
        start_sess(16'h0200);
        send_word(4'h1, 4'd6, 4'd1, 4'd2, 4'd0, 16'hBEEF, 1'b1, 3);
        // STORE, rd must not appear
        start_sess(16'h0300);
        send_word(4'h7, 4'd0, 4'd9, 4'd3, 4'd7, 16'h0010, 1'b1, 1);
        // illegal then legal last
        start_sess(16'h0400);
        send_word(4'b0101, 4'd1, 4'd2, 4'd3, 4'd4, 16'h5555, 1'b0, 0);
        send_word(4'h3, 4'd1, 4'd2, 4'd3, 4'd4, 16'hAAAA, 1'b1, 0);
        // illegal word that also ends the session
        start_sess(16'h0500);
        send_word(4'b1000, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b1, 0);
        // address wrap
        start_sess(16'hFFFF);
        send_word(4'hF, 4'd0, 4'd1, 4'd2, 4'd3, 16'h0001, 1'b0, 0);
        send_word(4'h3, 4'd0, 4'd4, 4'd5, 4'd6, 16'h0002, 1'b0, 2);
        send_word(4'h0, 4'd7, 4'd8, 4'd9, 4'd10, 16'h0003, 1'b1, 0);
        chk("wrap_count", count, 16'd3);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            int n;
            logic [3:0] op;
            logic [3:0] legal_ops [5];
            legal_ops = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
            n = $urandom_range(1, 6);
            start_sess(($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
            for (int w = 0; w < n; w++) begin
                op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
                send_word(op, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                          16'($urandom), 1'(w == n - 1), $urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset mid-WRITE after one write and one illegal word
        start_sess(16'h0800);
        send_word(4'h1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h0F0F, 1'b0, 0);
        send_word(4'b0010, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 0);
        in_valid = 1'b1; in_opc = 4'h3; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_we", mem_we, 1'b1);
        chk("pre_rst_err", err, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_count", count, 16'h0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_addr", mem_addr, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        chk("post_rst_we", mem_we, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_count", count, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
